fft16_sequencer: RTL
====================

# fft16_sequencer

Control sequencer for the 16-point radix-2 DIT FFT datapath. It walks the 4 stages × 8 butterflies, issuing a read-address pair and a twiddle-ROM index for each butterfly. It also emits the matching write-back strobe after the butterfly pipeline latency and inserts drain cycles between stages, so a stage never reads data the previous stage has not yet written. It sits beside the twiddle ROM and butterfly array and drives their address and select inputs; one shared butterfly is issued per cycle.

## Interface
Parameters:
- BF_LAT, 2, butterfly pipeline latency in cycles, legal range 1..7
- N, 16, datapath word width; not used internally, kept for top-level parameter passing

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-low reset (one clock; reset is synchronous and active-low)
- i_start  in  1  start request; sampled only in IDLE
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse when the transform completes
- o_issue  out  1  butterfly issue strobe
- o_rd_a  out  4  upper-leg sample address
- o_rd_b  out  4  lower-leg sample address
- o_tw_idx  out  3  twiddle ROM index (0..7)
- o_stage  out  2  current stage 0..3
- o_wr_en  out  1  write-back strobe
- o_wr_a  out  4  write-back address, upper leg
- o_wr_b  out  4  write-back address, lower leg
- i_in_valid  in  1  input sample valid (FFT16_SEQ_BITREV_EN only)
- o_ld_wr_en  out  1  load write strobe (FFT16_SEQ_BITREV_EN only)
- o_ld_addr  out  4  bit-reversed load address (FFT16_SEQ_BITREV_EN only)

## Operation
- States: IDLE, LOAD (macro only), ISSUE, DRAIN, DONE.
- IDLE: when i_start=1, go to LOAD if the macro is defined, else ISSUE; stage=0, bf=0.
- ISSUE: one butterfly per cycle, o_issue=1. For stage s and butterfly b:
  - span = 1<<s; o_rd_a = ((b>>s)<<(s+1)) | (b & (span-1)); o_rd_b = o_rd_a + span
  - o_tw_idx = (b & (span-1)) << (3-s)
  - After b=7, go to DRAIN.
- DRAIN: exactly BF_LAT cycles with o_issue=0. Then stage<3 → stage+1, ISSUE, bf=0; stage=3 → DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- Write-back: o_wr_en/o_wr_a/o_wr_b equal o_issue/o_rd_a/o_rd_b delayed by exactly BF_LAT cycles, via a shift register that runs in every state.
- i_start outside IDLE, including in DONE, is ignored; it is not queued.
- Reset mid-operation: next cycle IDLE, all outputs 0, delay line cleared, so no pending o_wr_en survives.
- Counters: bf is 3 bits, stage 2 bits, drain counter 3 bits; no wrap beyond the transitions above.

## Timing
- All outputs are registered; reset value of every output is 0.
- i_start sampled high at cycle 0 → first o_issue at cycle 1 (no-macro case).
- Issue cycles per stage: 8; stage period: 8+BF_LAT.
- Last write of a stage lands in the final DRAIN cycle; first read of the next stage follows it in the next cycle.
- o_done at cycle 4·(8+BF_LAT)+1 after start; 41 cycles for BF_LAT=2. o_busy falls in the same cycle o_done falls.
- A new i_start is accepted in the IDLE cycle following DONE at the earliest.

## Configuration
- FFT16_SEQ_BITREV_EN defined: LOAD state added.
  - Each cycle with i_in_valid=1: o_ld_wr_en=1, o_ld_addr = bit-reverse of a 4-bit load counter.
  - After the 16th sample, go to ISSUE. i_in_valid=0 stalls LOAD indefinitely.
  - o_done latency increases by the load duration.
- Not defined: LOAD and its three ports do not exist; input memory is preloaded externally in bit-reversed order.

## Structure
- Package fft16_pkg holds:
  - FFT_PTS=16, FFT_LOG2=4, BF_PER_STAGE=8
  - state encoding
  - bitrev4 function
- Sub-module fft16_addr_gen: combinational (stage, bf) → rd_a, rd_b, tw_idx.
- State machine and write-back delay line live in the top.

## Test plan
- Reset held low with i_start=1 → all outputs 0, state IDLE, no o_issue.
- Single run, BF_LAT=2:
  - stage 0 issues (0,1),(2,3)…(14,15), tw=0
  - stage 3 issues (0,8),(1,9)…(7,15), tw 0..7
  - o_done at cycle 41
- Stage 1, b=3 → rd_a=6, rd_b=8? No: rd_a=5, rd_b=7, tw=4. Stage 2, b=5 → rd_a=9, rd_b=13, tw=2.
- Every o_wr_en is exactly BF_LAT cycles after its o_issue with identical addresses. Check for BF_LAT=1 and BF_LAT=7; o_done at cycles 37 and 61.
- i_start pulsed at cycles 10 and 41 (the DONE cycle) → ignored; i_start at cycle 42 → new run, first issue at 43.
- i_rst low at cycle 20 → cycle 21 IDLE, o_wr_en stays 0 thereafter.
- With FFT16_SEQ_BITREV_EN: 16 valid samples with a bubble after sample 5 → o_ld_addr sequence 0,8,4,12,2,10…,15, then ISSUE.

Source files
------------

// File: rtl/fft16_pkg.sv
// Shared constants, state encoding and helpers for the 16-point FFT sequencer.
package fft16_pkg;

    localparam int FFT_PTS      = 16;
    localparam int FFT_LOG2     = 4;
    localparam int BF_PER_STAGE = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // Mirror a 4-bit sample index into bit-reversed load order.
    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/fft16_addr_gen.sv
// Butterfly address / twiddle-index generator for a radix-2 DIT 16-point FFT.
// Pure combinational map (stage, butterfly) -> (upper leg, lower leg, twiddle).
module fft16_addr_gen (
    input  logic [1:0] stage_i,
    input  logic [2:0] bf_i,
    output logic [3:0] rd_a_o,
    output logic [3:0] rd_b_o,
    output logic [2:0] tw_idx_o
);

    logic [3:0] span;

    // Upper leg inserts a zero at bit position 'stage'; lower leg sets that bit.
    always_comb begin
        rd_a_o   = '0;
        tw_idx_o = '0;
        span     = 4'd1 << stage_i;
        unique case (stage_i)
            2'd0: begin
                rd_a_o   = {bf_i, 1'b0};
                tw_idx_o = 3'd0;
            end
            2'd1: begin
                rd_a_o   = {bf_i[2:1], 1'b0, bf_i[0]};
                tw_idx_o = {bf_i[0], 2'b00};
            end
            2'd2: begin
                rd_a_o   = {bf_i[2], 1'b0, bf_i[1:0]};
                tw_idx_o = {bf_i[1:0], 1'b0};
            end
            2'd3: begin
                rd_a_o   = {1'b0, bf_i};
                tw_idx_o = bf_i;
            end
            default: begin
                rd_a_o   = '0;
                tw_idx_o = '0;
            end
        endcase
        rd_b_o = rd_a_o | span;
    end

endmodule

// File: rtl/fft16_sequencer.sv
// Control sequencer for the 16-point radix-2 DIT FFT datapath.
// Walks 4 stages x 8 butterflies, one butterfly per cycle, with BF_LAT drain
// cycles between stages and a BF_LAT-deep write-back delay line.
// Optional feature: FFT16_SEQ_BITREV_EN adds a LOAD state that writes 16 input
// samples to bit-reversed addresses before the first stage.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for i_start
// LOAD     | accepting input samples (FFT16_SEQ_BITREV_EN only)
// ISSUE    | one butterfly issued per cycle, bf 0..7
// DRAIN    | BF_LAT idle cycles so the stage's last write lands
// DONE     | one-cycle completion pulse
module fft16_sequencer
    import fft16_pkg::*;
#(
    parameter int BF_LAT = 2,
    parameter int N      = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_issue,
    output logic [3:0] o_rd_a,
    output logic [3:0] o_rd_b,
    output logic [2:0] o_tw_idx,
    output logic [1:0] o_stage,
    output logic       o_wr_en,
    output logic [3:0] o_wr_a,
    output logic [3:0] o_wr_b
`ifdef FFT16_SEQ_BITREV_EN
    ,
    input  logic       i_in_valid,
    output logic       o_ld_wr_en,
    output logic [3:0] o_ld_addr
`endif
);

    // N is only carried for top-level parameter passing; any legal N leaves
    // the delay depth equal to BF_LAT.
    localparam int         WB_DEPTH = (N >= 1) ? BF_LAT : 1;
    localparam logic [2:0] DRN_INIT = 3'(BF_LAT - 1);

    seq_state_e state_q, state_d;
    logic [2:0] bf_q, bf_d;
    logic [1:0] stage_q, stage_d;
    logic [2:0] drn_q, drn_d;

    logic       busy_q, done_q, issue_q;
    logic [3:0] rd_a_q, rd_b_q;
    logic [2:0] tw_q;

    logic [3:0] gen_rd_a, gen_rd_b;
    logic [2:0] gen_tw;

    logic [8:0] wb_q [WB_DEPTH];

`ifdef FFT16_SEQ_BITREV_EN
    logic [3:0] ld_cnt_q, ld_cnt_d;
    logic       ld_wr_en_q;
    logic [3:0] ld_addr_q;
`endif

    // Addresses are generated from the next counters so they register in
    // the same edge as the state that issues them.
    fft16_addr_gen u_addr_gen (
        .stage_i  (stage_d),
        .bf_i     (bf_d),
        .rd_a_o   (gen_rd_a),
        .rd_b_o   (gen_rd_b),
        .tw_idx_o (gen_tw)
    );

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        bf_d    = bf_q;
        stage_d = stage_q;
        drn_d   = drn_q;
`ifdef FFT16_SEQ_BITREV_EN
        ld_cnt_d = ld_cnt_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
`ifdef FFT16_SEQ_BITREV_EN
                    state_d  = ST_LOAD;
                    ld_cnt_d = '0;
`else
                    state_d  = ST_ISSUE;
`endif
                    bf_d    = '0;
                    stage_d = '0;
                end
            end
`ifdef FFT16_SEQ_BITREV_EN
            ST_LOAD: begin
                if (i_in_valid) begin
                    ld_cnt_d = ld_cnt_q + 4'd1;
                    if (ld_cnt_q == 4'(FFT_PTS - 1)) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
`endif
            ST_ISSUE: begin
                if (bf_q == 3'(BF_PER_STAGE - 1)) begin
                    state_d = ST_DRAIN;
                    drn_d   = DRN_INIT;
                end else begin
                    bf_d = bf_q + 3'd1;
                end
            end
            ST_DRAIN: begin
                if (drn_q == 3'd0) begin
                    if (stage_q == 2'(FFT_LOG2 - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_ISSUE;
                        stage_d = stage_q + 2'd1;
                        bf_d    = '0;
                    end
                end else begin
                    drn_d = drn_q - 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                stage_d = '0;
                bf_d    = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State machine registers and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
            bf_q    <= '0;
            stage_q <= '0;
            drn_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            issue_q <= 1'b0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            tw_q    <= '0;
`ifdef FFT16_SEQ_BITREV_EN
            ld_cnt_q   <= '0;
            ld_wr_en_q <= 1'b0;
            ld_addr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            bf_q    <= bf_d;
            stage_q <= stage_d;
            drn_q   <= drn_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            issue_q <= (state_d == ST_ISSUE);
            rd_a_q  <= (state_d == ST_ISSUE) ? gen_rd_a : 4'd0;
            rd_b_q  <= (state_d == ST_ISSUE) ? gen_rd_b : 4'd0;
            tw_q    <= (state_d == ST_ISSUE) ? gen_tw   : 3'd0;
`ifdef FFT16_SEQ_BITREV_EN
            ld_cnt_q   <= ld_cnt_d;
            ld_wr_en_q <= (state_q == ST_LOAD) && i_in_valid;
            ld_addr_q  <= ((state_q == ST_LOAD) && i_in_valid) ? bitrev4(ld_cnt_q) : 4'd0;
`endif
        end
    end

    // Write-back delay line: replays issue strobe and addresses BF_LAT cycles later.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            for (int k = 0; k < WB_DEPTH; k++) wb_q[k] <= '0;
        end else begin
            wb_q[0] <= {issue_q, rd_a_q, rd_b_q};
            for (int k = 1; k < WB_DEPTH; k++) wb_q[k] <= wb_q[k-1];
        end
    end

    assign o_busy   = busy_q;
    assign o_done   = done_q;
    assign o_issue  = issue_q;
    assign o_rd_a   = rd_a_q;
    assign o_rd_b   = rd_b_q;
    assign o_tw_idx = tw_q;
    assign o_stage  = stage_q;
    assign o_wr_en  = wb_q[WB_DEPTH-1][8];
    assign o_wr_a   = wb_q[WB_DEPTH-1][7:4];
    assign o_wr_b   = wb_q[WB_DEPTH-1][3:0];
`ifdef FFT16_SEQ_BITREV_EN
    assign o_ld_wr_en = ld_wr_en_q;
    assign o_ld_addr  = ld_addr_q;
`endif

endmodule
